// File: rtl/symbol_bits_packer_pkg.sv
// Shared types and elaboration helpers for the symbol-to-word bit packer.
// The packer alternates between accepting symbols and draining a leftover residue word.
package symbol_bits_packer_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    FLUSH = 1'b1
  } packer_state_e;

  function automatic bit params_legal(input int bits_in, input int width_out);
    return ((bits_in == 2) || (bits_in == 4) || (bits_in == 6)) &&
           (width_out >= 8) && ((width_out % 8) == 0) && (width_out >= bits_in);
  endfunction

endpackage

// File: rtl/symbol_bits_packer.sv
// Packs BITS_IN-bit gray-mapped symbols MSB-first into WIDTH_OUT-bit AXI-Stream words,
// emitting a zero-padded partial word (o_tuser = valid bits) at the end of each packet.
module symbol_bits_packer
  import symbol_bits_packer_pkg::*;
#(
  parameter int BITS_IN   = 6,
  parameter int WIDTH_OUT = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic [BITS_IN-1:0]         i_tdata,
  input  logic                       i_tlast,
  input  logic                       i_tvalid,
  output logic                       i_tready,
  output logic [WIDTH_OUT-1:0]       o_tdata,
  output logic                       o_tlast,
  output logic                       o_tvalid,
  input  logic                       o_tready,
  output logic [$clog2(WIDTH_OUT):0] o_tuser
);

  localparam int ACC_W  = WIDTH_OUT + BITS_IN;
  localparam int CNT_W  = $clog2(ACC_W + 1);
  localparam int USER_W = $clog2(WIDTH_OUT) + 1;
  localparam logic [CNT_W-1:0]  BITS_C    = CNT_W'(BITS_IN);
  localparam logic [CNT_W-1:0]  WIDTH_C   = CNT_W'(WIDTH_OUT);
  localparam logic [USER_W-1:0] FULL_USER = USER_W'(WIDTH_OUT);

  generate
    if (!params_legal(BITS_IN, WIDTH_OUT)) begin : g_illegal_params
      $error("symbol_bits_packer: illegal BITS_IN/WIDTH_OUT combination");
    end
  endgenerate

  packer_state_e       state_q, state_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WIDTH_OUT-1:0] data_q, data_d;
  logic                last_q, last_d;
  logic [USER_W-1:0]   user_q, user_d;
  logic                valid_q, valid_d;

  logic                in_hs;
  logic                out_hs;
  logic [ACC_W-1:0]    merged;
  logic [CNT_W-1:0]    total;
  logic [CNT_W-1:0]    residue;
  logic                word_full;

  // Valid bits live left-aligned in acc_q; everything below cnt_q is kept zero.
  assign i_tready  = reset_n && (state_q == FILL) && (!valid_q || o_tready);
  assign in_hs     = i_tvalid && i_tready;
  assign out_hs    = valid_q && o_tready;
  assign merged    = acc_q | ({i_tdata, {WIDTH_OUT{1'b0}}} >> cnt_q);
  assign total     = cnt_q + BITS_C;
  assign residue   = total - WIDTH_C;
  assign word_full = (total >= WIDTH_C);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    last_d  = last_q;
    user_d  = user_q;
    valid_d = valid_q && !out_hs;

    unique case (state_q)
      FILL: begin
        if (in_hs) begin
          if (word_full) begin
            data_d  = merged[ACC_W-1 -: WIDTH_OUT];
            user_d  = FULL_USER;
            valid_d = 1'b1;
            acc_d   = merged << WIDTH_OUT;
            cnt_d   = residue;
            last_d  = i_tlast && (residue == '0);
            if (i_tlast && (residue != '0)) begin
              state_d = FLUSH;
            end
          end else if (i_tlast) begin
            data_d  = merged[ACC_W-1 -: WIDTH_OUT];
            user_d  = USER_W'(total);
            last_d  = 1'b1;
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            acc_d = merged;
            cnt_d = total;
          end
        end
      end

      FLUSH: begin
        // The residue word replaces the full word on the cycle it is taken.
        if (out_hs) begin
          data_d  = acc_q[ACC_W-1 -: WIDTH_OUT];
          user_d  = USER_W'(cnt_q);
          last_d  = 1'b1;
          valid_d = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = FILL;
        end
      end

      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      state_q <= FILL;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      user_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      last_q  <= last_d;
      user_q  <= user_d;
      valid_q <= valid_d;
    end
  end

  assign o_tdata  = data_q;
  assign o_tlast  = last_q;
  assign o_tuser  = user_q;
  assign o_tvalid = valid_q;

endmodule

// File: tb/tb_symbol_bits_packer.sv
// Scoreboard bench for symbol_bits_packer: three instances (BITS_IN = 2, 4, 6; WIDTH_OUT = 32)
// driven with directed packets whose packed words were worked out by hand.
module tb_symbol_bits_packer;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
    logic [5:0]   user;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  logic clear;

  // Index 0: BITS_IN=2, index 1: BITS_IN=4, index 2: BITS_IN=6
  logic [5:0]   s_data  [3];
  logic         s_last  [3];
  logic         s_valid [3];
  logic         s_ready [3];
  logic [W-1:0] m_data  [3];
  logic         m_last  [3];
  logic         m_valid [3];
  logic         m_ready [3];
  logic [5:0]   m_user  [3];

  exp_t         exp_q [3][$];
  bit           hold_pend [3] = '{1'b0, 1'b0, 1'b0};
  logic [63:0]  held_word [3];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int B = (g == 0) ? 2 : ((g == 1) ? 4 : 6);
    symbol_bits_packer #(
      .BITS_IN   (B),
      .WIDTH_OUT (W)
    ) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear    (clear),
      .i_tdata  (s_data[g][B-1:0]),
      .i_tlast  (s_last[g]),
      .i_tvalid (s_valid[g]),
      .i_tready (s_ready[g]),
      .o_tdata  (m_data[g]),
      .o_tlast  (m_last[g]),
      .o_tvalid (m_valid[g]),
      .o_tready (m_ready[g]),
      .o_tuser  (m_user[g])
    );
  end

  task automatic check_value(input string name, input logic [63:0] actual, input logic [63:0] required);
    n_cmp++;
    if (actual !== required) begin
      n_fail++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic check_output(input int k);
    exp_t e;
    n_cmp++;
    if (exp_q[k].size() == 0) begin
      n_fail++;
      $display("[TB] FAIL unexpected_word_dut%0d actual=%h/%0b/%0d required=none", k, m_data[k], m_last[k], m_user[k]);
    end else begin
      e = exp_q[k].pop_front();
      if (m_data[k] !== e.data || m_last[k] !== e.last || m_user[k] !== e.user) begin
        n_fail++;
        $display("[TB] FAIL word_dut%0d actual=%h/%0b/%0d required=%h/%0b/%0d",
                 k, m_data[k], m_last[k], m_user[k], e.data, e.last, e.user);
      end
    end
  endtask

  // Monitor: words are taken at the negedge before the accepting posedge; held words must not move.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (hold_pend[k]) begin
        check_value($sformatf("hold_valid_dut%0d", k), 64'(m_valid[k]), 64'd1);
        check_value($sformatf("hold_word_dut%0d", k), {25'd0, m_data[k], m_last[k], m_user[k]}, held_word[k]);
      end
      hold_pend[k] = reset_n && !clear && m_valid[k] && !m_ready[k];
      held_word[k] = {25'd0, m_data[k], m_last[k], m_user[k]};
      if (reset_n && !clear && m_valid[k] && m_ready[k]) begin
        check_output(k);
      end
    end
  end

  task automatic push_exp(input int k, input logic [W-1:0] data, input logic last, input logic [5:0] user);
    exp_t e;
    e.data = data;
    e.last = last;
    e.user = user;
    exp_q[k].push_back(e);
  endtask

  task automatic apply_stimulus(input int k, input logic [5:0] sym, input logic last);
    int guard = 0;
    s_data[k]  = sym;
    s_last[k]  = last;
    s_valid[k] = 1'b1;
    forever begin
      @(negedge clk);
      if (s_ready[k]) break;
      guard++;
      if (guard > 200) begin
        n_cmp++;
        n_fail++;
        $display("[TB] FAIL accept_timeout_dut%0d actual=ready_low required=ready_high", k);
        break;
      end
    end
    @(posedge clk);
    #1;
    s_valid[k] = 1'b0;
    s_last[k]  = 1'b0;
  endtask

  task automatic wait_drain();
    int guard = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check_value("drain_pending_words", 64'(exp_q[0].size() + exp_q[1].size() + exp_q[2].size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  // 0x3F/0x00 alternating symbols on the 6-bit lane: 96 bits, three full words, no residue.
  task automatic run_stripe_packet(input bit stall);
    push_exp(2, 32'hFC0FC0FC, 1'b0, 6'd32);
    push_exp(2, 32'h0FC0FC0F, 1'b0, 6'd32);
    push_exp(2, 32'hC0FC0FC0, 1'b1, 6'd32);
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          apply_stimulus(2, (i % 2 == 0) ? 6'h3F : 6'h00, i == 15);
        end
      end
      begin
        if (stall) begin
          repeat (3) @(posedge clk);
          #1;
          m_ready[2] = 1'b0;
          repeat (10) @(posedge clk);
          #1;
          check_value("stall_word_pending", 64'(m_valid[2]), 64'd1);
          check_value("stall_input_ready", 64'(s_ready[2]), 64'd0);
          m_ready[2] = 1'b1;
        end
      end
    join
    wait_drain();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    clear   = 1'b0;
    for (int k = 0; k < 3; k++) begin
      s_data[k]  = '0;
      s_last[k]  = 1'b0;
      s_valid[k] = 1'b0;
      m_ready[k] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check_value($sformatf("reset_valid_dut%0d", k), 64'(m_valid[k]), 64'd0);
      check_value($sformatf("reset_data_dut%0d", k), 64'(m_data[k]), 64'd0);
      check_value($sformatf("reset_last_dut%0d", k), 64'(m_last[k]), 64'd0);
      check_value($sformatf("reset_user_dut%0d", k), 64'(m_user[k]), 64'd0);
      check_value($sformatf("reset_ready_dut%0d", k), 64'(s_ready[k]), 64'd0);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check_value($sformatf("idle_ready_dut%0d", k), 64'(s_ready[k]), 64'd1);
    end

    $display("[TB] 4-bit partial word 9,5,3");
    push_exp(1, 32'h95300000, 1'b1, 6'd12);
    apply_stimulus(1, 6'h9, 1'b0);
    apply_stimulus(1, 6'h5, 1'b0);
    apply_stimulus(1, 6'h3, 1'b1);
    wait_drain();

    $display("[TB] 2-bit exact word 3,0,1,2 x4");
    push_exp(0, 32'hC6C6C6C6, 1'b1, 6'd32);
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(0, 6'((i % 4 == 0) ? 3 : ((i % 4 == 1) ? 0 : ((i % 4 == 2) ? 1 : 2))), i == 15);
    end
    wait_drain();

    $display("[TB] 2-bit single symbol packet");
    push_exp(0, 32'h80000000, 1'b1, 6'd2);
    apply_stimulus(0, 6'h2, 1'b1);
    wait_drain();

    $display("[TB] 6-bit all ones, three words");
    push_exp(2, 32'hFFFFFFFF, 1'b0, 6'd32);
    push_exp(2, 32'hFFFFFFFF, 1'b0, 6'd32);
    push_exp(2, 32'hFFFFFFFF, 1'b1, 6'd32);
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(2, 6'h3F, i == 15);
    end
    wait_drain();

    $display("[TB] 6-bit residue flush");
    push_exp(2, 32'hAAAAAAAA, 1'b0, 6'd32);
    push_exp(2, 32'hA0000000, 1'b1, 6'd4);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(2, 6'h2A, 1'b0);
    end
    m_ready[2] = 1'b0;
    apply_stimulus(2, 6'h2A, 1'b1);
    check_value("flush_ready_first", 64'(s_ready[2]), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check_value("flush_ready_held", 64'(s_ready[2]), 64'd0);
    check_value("flush_valid_held", 64'(m_valid[2]), 64'd1);
    m_ready[2] = 1'b1;
    wait_drain();
    check_value("flush_ready_after", 64'(s_ready[2]), 64'd1);

    $display("[TB] 6-bit stripes, free-running then stalled");
    run_stripe_packet(1'b0);
    run_stripe_packet(1'b1);

    $display("[TB] reset mid-packet");
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(2, 6'h3F, 1'b0);
    end
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    check_value("midreset_valid", 64'(m_valid[2]), 64'd0);
    reset_n = 1'b1;
    run_stripe_packet(1'b0);

    $display("[TB] clear beats simultaneous handshake");
    apply_stimulus(1, 6'hF, 1'b0);
    apply_stimulus(1, 6'hF, 1'b0);
    s_data[1]  = 6'hF;
    s_valid[1] = 1'b1;
    clear      = 1'b1;
    @(posedge clk);
    #1;
    clear      = 1'b0;
    s_valid[1] = 1'b0;
    check_value("clear_valid", 64'(m_valid[1]), 64'd0);
    push_exp(1, 32'h95300000, 1'b1, 6'd12);
    apply_stimulus(1, 6'h9, 1'b0);
    apply_stimulus(1, 6'h5, 1'b0);
    apply_stimulus(1, 6'h3, 1'b1);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
